// File: rtl/dpram_be_model.sv
// rtl/dpram_be_model.sv - dual-port RAM: port A byte-enable read/write, port B read-only
module dpram_be_model #(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 1024,
    parameter  int RD_LAT  = 1,
    parameter  int WR_MODE = 0,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NBYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              i_a_en,
    input  logic [NBYTES-1:0] i_a_wen,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic [DATA_W-1:0] o_a_data,
    output logic              o_a_valid,
    input  logic              i_b_en,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [DATA_W-1:0] o_b_data,
    output logic              o_b_valid,
    output logic              o_coll
);

    localparam int DEPTH_2N = 1 << ADDR_W;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("dpram_be_model: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("dpram_be_model: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH_2N];

    logic [DATA_W-1:0] a_old;
    logic [DATA_W-1:0] a_new;
    logic [DATA_W-1:0] b_old;
    logic              a_wr;
    logic              coll_now;

    always_comb begin
        a_old = mem[i_a_addr];
        b_old = mem[i_b_addr];
        a_new = a_old;
        for (int k = 0; k < NBYTES; k++) begin
            if (i_a_wen[k]) begin
                a_new[8*k +: 8] = i_a_data[8*k +: 8];
            end
        end
    end

    assign a_wr     = i_a_en && (|i_a_wen);
    assign coll_now = i_b_en && a_wr && (i_b_addr == i_a_addr);

    // Array is never cleared; the reset branch only blocks writes while aresetn is low.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
        end else if (a_wr) begin
            mem[i_a_addr] <= a_new;
        end
    end

    logic              a_valid_s1;
    logic [DATA_W-1:0] a_data_s1;
    logic              b_valid_s1;
    logic [DATA_W-1:0] b_data_s1;
    logic              coll_s1;

    // Port B always captures the pre-write word, so a collision never shows port A's new data.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_valid_s1 <= 1'b0;
            a_data_s1  <= '0;
            b_valid_s1 <= 1'b0;
            b_data_s1  <= '0;
            coll_s1    <= 1'b0;
        end else begin
            a_valid_s1 <= i_a_en;
            b_valid_s1 <= i_b_en;
            coll_s1    <= coll_now;
            if (i_a_en) begin
                a_data_s1 <= (WR_MODE != 0) ? a_new : a_old;
            end
            if (i_b_en) begin
                b_data_s1 <= b_old;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              a_valid_s2;
        logic [DATA_W-1:0] a_data_s2;
        logic              b_valid_s2;
        logic [DATA_W-1:0] b_data_s2;
        logic              coll_s2;

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                a_valid_s2 <= 1'b0;
                a_data_s2  <= '0;
                b_valid_s2 <= 1'b0;
                b_data_s2  <= '0;
                coll_s2    <= 1'b0;
            end else begin
                a_valid_s2 <= a_valid_s1;
                b_valid_s2 <= b_valid_s1;
                coll_s2    <= coll_s1;
                if (a_valid_s1) begin
                    a_data_s2 <= a_data_s1;
                end
                if (b_valid_s1) begin
                    b_data_s2 <= b_data_s1;
                end
            end
        end

        assign o_a_valid = a_valid_s2;
        assign o_a_data  = a_data_s2;
        assign o_b_valid = b_valid_s2;
        assign o_b_data  = b_data_s2;
        assign o_coll    = coll_s2;
    end else begin : g_lat1
        assign o_a_valid = a_valid_s1;
        assign o_a_data  = a_data_s1;
        assign o_b_valid = b_valid_s1;
        assign o_b_data  = b_data_s1;
        assign o_coll    = coll_s1;
    end

endmodule

// File: doc/dpram_be_model.md
Name: dpram_be_model

Overview:
Simple dual-port RAM model with byte-enable writes, the successor to the single-port synchronous RAM model.
- Port A is read/write; port B is read-only.
- Write mode (read-first / write-first) and read latency (1 or 2 cycles) are configurable.
- Each port has a read-valid output; a collision flag marks same-address A-write/B-read.
- Used as data memory for the pqr5 subsystem where the core and a debug/DMA reader share one array.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise)
DEPTH, 1024, number of words; implemented depth DEPTH_2N = 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
WR_MODE, 0, port A read-during-write: 0 = read-first (old word), 1 = write-first (merged new word)
ADDR_W, $clog2(DEPTH), derived localparam, address width
NBYTES, DATA_W/8, derived localparam, byte lanes

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
i_a_en  in  1  port A enable
i_a_wen  in  NBYTES  port A byte write enables, bit k writes bits [8k+7:8k]
i_a_addr  in  ADDR_W  port A address
i_a_data  in  DATA_W  port A write data
o_a_data  out  DATA_W  port A read data
o_a_valid  out  1  port A read data valid
i_b_en  in  1  port B read enable
i_b_addr  in  ADDR_W  port B address
o_b_data  out  DATA_W  port B read data
o_b_valid  out  1  port B read data valid
o_coll  out  1  collision flag, aligned with o_b_valid

Behaviour:
- Reset (aresetn low, asynchronous):
  - o_a_data, o_b_data, o_a_valid, o_b_valid and o_coll go to 0, as do all pipeline stage registers.
  - The memory array is not cleared and keeps its contents.
  - No memory write occurs on any edge where aresetn is low.
- Port A access (edge with i_a_en=1):
  - Every lane with i_a_wen[k]=1 is written; lanes with i_a_wen[k]=0 keep their old bytes.
  - A read is always performed, including when i_a_wen is nonzero.
  - WR_MODE=0: the returned word is the pre-write contents.
  - WR_MODE=1: the returned word is the post-write merged word (old bytes in disabled lanes, new bytes in enabled lanes).
  - i_a_wen=0 with i_a_en=1 is a pure read.
- Port A disabled (i_a_en=0): no read and no write; i_a_wen is ignored.
- Port B access (edge with i_b_en=1): reads the word at i_b_addr.
- Collision (port B vs port A write):
  - Condition: i_b_en=1, i_a_en=1, i_a_wen!=0 and i_b_addr==i_a_addr on the same edge.
  - Port B always returns the pre-write word, independent of WR_MODE.
  - o_coll=1 is delivered in the same cycle as that read's o_b_valid. Otherwise o_coll=0.
- Latency:
  - A read issued at edge N produces data and valid=1 after edge N+RD_LAT-1 + 1, i.e. visible in the cycle after edge N when RD_LAT=1, and one cycle later when RD_LAT=2.
  - valid is a 1-cycle pulse per read; back-to-back reads give back-to-back valids with full throughput.
  - RD_LAT=2 adds one output register per port in a fixed pipeline with no stall.
- Hold: each data register loads only when its upstream stage carries a valid read; otherwise it holds its last value. o_*_data is stable when o_*_valid=0.
- Port independence: ports A and B operate fully independently; simultaneous reads of the same address both return the same word.
- Address range: addresses in [DEPTH, DEPTH_2N) are legal storage.
- Reset mid-operation: in-flight reads are dropped (valids cleared, no late pulse after release). The first access is accepted on the first edge with aresetn=1.

Test Plan:
- Full-word write then read, RD_LAT=1: A writes 0xDEADBEEF to addr 5 (wen=4'hF), then reads addr 5 → o_a_data=0xDEADBEEF with o_a_valid=1 exactly one cycle after the read edge.
- Byte merge: with addr 5 holding 0xDEADBEEF, write 0x11223344 using wen=4'b0101 → a subsequent read returns 0xDE22BE44.
- Read-during-write on port A: addr 7 holds 0xAAAAAAAA; A writes 0x55555555 with wen=4'hF → read data is 0xAAAAAAAA when WR_MODE=0 and 0x55555555 when WR_MODE=1.
- Collision: on the same edge, A writes 0x12345678 to addr 9 (old value 0x0) and B reads addr 9 → o_b_data=0x0 with o_coll=1 and o_b_valid=1 together; a B read of addr 9 on the next edge returns 0x12345678 with o_coll=0.
- RD_LAT=2 streaming: B reads addr 0..7 (preloaded with 0x100+i) on 8 consecutive edges → 8 consecutive valid cycles starting 2 cycles after the first edge, with data 0x100..0x107 in order.
- Reset mid-read: issue a B read, then assert aresetn low before the valid cycle → o_b_valid never pulses and outputs are 0. After release, data written before reset reads back unchanged.
